// File: rtl/truth_table_checker.sv
// Sweeps all 16 input vectors of a 4-input lab function, captures its truth table and grades it against a golden table.
// Optional build macro: TRUTH_TABLE_CHECKER_STOP_ON_FAIL_EN ends the sweep on the first mismatching vector.
module truth_table_checker #(
    parameter int unsigned SETTLE   = 1,
    parameter logic [15:0] EXPECTED = 16'h22AA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        dut_a,
    output logic        dut_b,
    output logic        dut_c,
    output logic        dut_d,
    input  logic        dut_f,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] table_out,
    output logic [4:0]  fail_count,
    output logic [3:0]  first_fail_idx
);

    localparam int unsigned SCW = (SETTLE == 0) ? 1 : $clog2(SETTLE + 1);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [3:0]     idx;
    logic [SCW-1:0] settle_cnt;

    logic           sample_c;
    logic           mismatch_c;
    logic [4:0]     fail_count_nxt_c;

    // The index register is the stimulus vector, d being the LSB.
    assign dut_a = idx[3];
    assign dut_b = idx[2];
    assign dut_c = idx[1];
    assign dut_d = idx[0];

    assign sample_c         = (state == RUN) && (settle_cnt == SETTLE_LAST);
    assign mismatch_c       = (dut_f != EXPECTED[idx]);
    assign fail_count_nxt_c = fail_count + 5'(mismatch_c);

    // Sweep FSM with all results registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= 4'd0;
            settle_cnt     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            table_out      <= 16'd0;
            fail_count     <= 5'd0;
            first_fail_idx <= 4'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= RUN;
                        idx            <= 4'd0;
                        settle_cnt     <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        table_out      <= 16'd0;
                        fail_count     <= 5'd0;
                        first_fail_idx <= 4'd0;
                    end
                end
                RUN: begin
                    if (!sample_c) begin
                        settle_cnt <= settle_cnt + SCW'(1);
                    end else begin
                        table_out[idx] <= dut_f;
                        if (mismatch_c) begin
                            fail_count <= fail_count_nxt_c;
                            if (fail_count == 5'd0) begin
                                first_fail_idx <= idx;
                            end
                        end
`ifdef TRUTH_TABLE_CHECKER_STOP_ON_FAIL_EN
                        if (mismatch_c) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b0;
                        end else if (idx == 4'd15) begin
`else
                        if (idx == 4'd15) begin
`endif
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (fail_count_nxt_c == 5'd0);
                        end else begin
                            idx        <= idx + 4'd1;
                            settle_cnt <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
